// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: ctrl bit positions and named Hack ALU opcodes
package alu_pipe_pkg;
   localparam int CTRL_ZX = 5;
   localparam int CTRL_NX = 4;
   localparam int CTRL_ZY = 3;
   localparam int CTRL_NY = 2;
   localparam int CTRL_F  = 1;
   localparam int CTRL_NO = 0;
   localparam logic [5:0] OP_ZERO   = 6'b101010;
   localparam logic [5:0] OP_ONE    = 6'b111111;
   localparam logic [5:0] OP_NEG1   = 6'b111010;
   localparam logic [5:0] OP_X      = 6'b001100;
   localparam logic [5:0] OP_Y      = 6'b110000;
   localparam logic [5:0] OP_NOT_X  = 6'b001101;
   localparam logic [5:0] OP_NEG_X  = 6'b001111;
   localparam logic [5:0] OP_ADD    = 6'b000010;
   localparam logic [5:0] OP_SUB_XY = 6'b010011;
   localparam logic [5:0] OP_SUB_YX = 6'b000111;
   localparam logic [5:0] OP_AND    = 6'b000000;
   localparam logic [5:0] OP_OR     = 6'b010101;
endpackage

// File: rtl/alu_preset.sv
// alu_preset: operand zero/negate preconditioning for one ALU input
module alu_preset #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] d,
   input  logic             z,
   input  logic             n,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] dz;
   assign dz = z ? '0 : d;
   assign q  = n ? ~dz : dz;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack ALU with valid/ready on both sides and carry/overflow flags
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy,
   output logic             ov
);
   logic             s1_valid, f1, no1, s1_adv;
   logic [WIDTH-1:0] xp, yp, x1, y1, r, res;
   logic [WIDTH:0]   sum;

   alu_preset #(.WIDTH(WIDTH)) u_px (.d(x), .z(ctrl[CTRL_ZX]), .n(ctrl[CTRL_NX]), .q(xp));
   alu_preset #(.WIDTH(WIDTH)) u_py (.d(y), .z(ctrl[CTRL_ZY]), .n(ctrl[CTRL_NY]), .q(yp));

   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s1_adv;
   assign sum      = {1'b0, x1} + {1'b0, y1};
   assign r        = f1 ? sum[WIDTH-1:0] : (x1 & y1);
   assign res      = no1 ? ~r : r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         x1       <= '0;
         y1       <= '0;
         f1       <= 1'b0;
         no1      <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            x1  <= xp;
            y1  <= yp;
            f1  <= ctrl[CTRL_F];
            no1 <= ctrl[CTRL_NO];
         end
      end
   end

   // carry/overflow describe the adder itself, so they ignore the final inversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cy        <= 1'b0;
         ov        <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out <= res;
            zr  <= (res == '0);
            ng  <= res[WIDTH-1];
            cy  <= f1 & sum[WIDTH];
            ov  <= f1 & (x1[WIDTH-1] == y1[WIDTH-1]) & (sum[WIDTH-1] != x1[WIDTH-1]);
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=16 and WIDTH=8
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, zr, ng, cy, ov;
   logic [15:0] x, y, out;
   logic [5:0]  ctrl;
   logic        in_valid8, in_ready8, out_valid8, out_ready8, zr8, ng8, cy8, ov8;
   logic [7:0]  x8, y8, out8;
   logic [5:0]  ctrl8;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr), .ng(ng),
      .cy(cy), .ov(ov)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8),
      .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .zr(zr8),
      .ng(ng8), .cy(cy8), .ov(ov8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                         output logic [15:0] o, output logic [3:0] fl, output bit late);
      in_valid = 1'b1; x = a; y = b; ctrl = c; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      late = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            late = 1'b0;
            break;
         end
         tick();
      end
      o = out;
      fl = {zr, ng, cy, ov};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; ctrl = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0; ctrl8 = '0;
      #3;
      total++;
      if ({out_valid, in_ready, zr, ng, cy, ov} !== 6'b010000 || out !== 16'h0) begin
         bad++;
         $display("FAIL reset16 got v/r/flags=%b out=%h exp 010000 out=0000",
                  {out_valid, in_ready, zr, ng, cy, ov}, out);
      end
      total++;
      if ({out_valid8, in_ready8, zr8, ng8, cy8, ov8} !== 6'b010000 || out8 !== 8'h0) begin
         bad++;
         $display("FAIL reset8 got v/r/flags=%b out=%h exp 010000 out=00",
                  {out_valid8, in_ready8, zr8, ng8, cy8, ov8}, out8);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_zero_latency();
      in_valid = 1'b1; x = 16'h1234; y = 16'h5678; ctrl = OP_ZERO; out_ready = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_in_ready got=%b exp=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_early_valid got=%b exp=0", out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out !== 16'h0 || zr !== 1'b1 || ng !== 1'b0) begin
         bad++;
         $display("FAIL zero_result got v=%b out=%h zr=%b ng=%b exp v=1 out=0000 zr=1 ng=0",
                  out_valid, out, zr, ng);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      x = 16'd5; y = 16'd3; out_ready = 1'b1; in_valid = 1'b1;
      ctrl = OP_ADD;
      tick();
      ctrl = OP_SUB_XY;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first_valid got=%b exp=0", out_valid);
      end
      tick();
      ctrl = OP_SUB_YX;
      total++;
      if (out_valid !== 1'b1 || out !== 16'd8 || ng !== 1'b0) begin
         bad++;
         $display("FAIL b2b_add got v=%b out=%h ng=%b exp v=1 out=0008 ng=0", out_valid, out, ng);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out !== 16'd2) begin
         bad++;
         $display("FAIL b2b_sub_xy got v=%b out=%h exp v=1 out=0002", out_valid, out);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out !== 16'hFFFE || ng !== 1'b1 || zr !== 1'b0) begin
         bad++;
         $display("FAIL b2b_sub_yx got v=%b out=%h ng=%b zr=%b exp v=1 out=fffe ng=1 zr=0",
                  out_valid, out, ng, zr);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain got v=%b exp=0", out_valid);
      end
   endtask

   task automatic test_flags();
      logic [15:0] o;
      logic [3:0]  fl;
      bit          late;
      run_op(16'h7FFF, 16'h0001, OP_ADD, o, fl, late);
      total++;
      if (late || o !== 16'h8000 || fl !== 4'b0101) begin
         bad++;
         $display("FAIL flags_ovf got late=%b out=%h zr/ng/cy/ov=%b exp out=8000 flags=0101",
                  late, o, fl);
      end
      run_op(16'hFFFF, 16'h0001, OP_ADD, o, fl, late);
      total++;
      if (late || o !== 16'h0000 || fl !== 4'b1010) begin
         bad++;
         $display("FAIL flags_carry got late=%b out=%h zr/ng/cy/ov=%b exp out=0000 flags=1010",
                  late, o, fl);
      end
      run_op(16'h8000, 16'h8000, OP_AND, o, fl, late);
      total++;
      if (late || o !== 16'h8000 || fl !== 4'b0100) begin
         bad++;
         $display("FAIL flags_logic got late=%b out=%h zr/ng/cy/ov=%b exp out=8000 flags=0100",
                  late, o, fl);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [15:0] exp_q [4] = '{16'd11, 16'd12, 16'd13, 16'd14};
      int n = 0;
      int k = 0;
      out_ready = 1'b0; y = 16'd10; ctrl = OP_ADD;
      for (int c = 0; c < 7; c++) begin
         in_valid = (n < 4);
         x = 16'(n + 1);
         #1;
         if (in_valid && in_ready) n++;
         tick();
         if (out_valid) begin
            total++;
            if (out !== 16'd11) begin
               bad++;
               $display("FAIL stall_hold cycle=%0d got out=%h exp=000b", c, out);
            end
         end
      end
      in_valid = (n < 4);
      x = 16'(n + 1);
      #1;
      total++;
      if (n !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_backpressure got accepts=%0d in_ready=%b v=%b exp accepts=2 in_ready=0 v=1",
                  n, in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         in_valid = (n < 4);
         x = 16'(n + 1);
         #1;
         if (out_valid) begin
            total++;
            if (out !== exp_q[k]) begin
               bad++;
               $display("FAIL stall_order idx=%0d got out=%h exp=%h", k, out, exp_q[k]);
            end
            k++;
         end
         if (in_valid && in_ready) n++;
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (k !== 4 || n !== 4) begin
         bad++;
         $display("FAIL stall_count got pops=%0d accepts=%0d exp 4 and 4", k, n);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_dup got v=%b exp=0", out_valid);
      end
   endtask

   task automatic test_async_reset();
      x = 16'd5; y = 16'd3; ctrl = OP_ADD; out_ready = 1'b0; in_valid = 1'b1;
      tick();
      tick();
      tick();
      total++;
      if (out_valid !== 1'b1 || out !== 16'd8) begin
         bad++;
         $display("FAIL rst_pre got v=%b out=%h exp v=1 out=0008", out_valid, out);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out !== 16'h0 || {zr, ng, cy, ov} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_async got v=%b out=%h flags=%b exp v=0 out=0000 flags=0000",
                  out_valid, out, {zr, ng, cy, ov});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #2 rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_release got in_ready=%b v=%b exp in_ready=1 v=0", in_ready, out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_dropped got v=%b exp=0", out_valid);
      end
   endtask

   task automatic test_width8();
      out_ready8 = 1'b1; in_valid8 = 1'b1; x8 = 8'h80; y8 = 8'h80;
      ctrl8 = OP_NOT_X;
      tick();
      ctrl8 = OP_ADD;
      tick();
      in_valid8 = 1'b0;
      total++;
      if (out_valid8 !== 1'b1 || out8 !== 8'h7F || ng8 !== 1'b0 || zr8 !== 1'b0) begin
         bad++;
         $display("FAIL w8_not got v=%b out=%h ng=%b zr=%b exp v=1 out=7f ng=0 zr=0",
                  out_valid8, out8, ng8, zr8);
      end
      tick();
      total++;
      if (out_valid8 !== 1'b1 || out8 !== 8'h00 || {zr8, ng8, cy8, ov8} !== 4'b1011) begin
         bad++;
         $display("FAIL w8_add got v=%b out=%h zr/ng/cy/ov=%b exp v=1 out=00 flags=1011",
                  out_valid8, out8, {zr8, ng8, cy8, ov8});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_back_to_back();
      test_flags();
      test_stall();
      test_async_reset();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
